// File: rtl/vga_framebuffer_scaled.sv
// ============================================================================
//  Module  : vga_framebuffer_scaled
//  Purpose : VGA scan-out from a QSPI-RAM framebuffer with integer pixel/line
//            repeat; repeated lines are replayed from an internal line buffer.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vga_framebuffer_scaled #(
    parameter int LINE_VISIBLE     = 640,
    parameter int LINE_FRONT_PORCH = 16,
    parameter int LINE_SYNC_PULSE  = 96,
    parameter int LINE_BACK_PORCH  = 48,
    parameter int ROW_VISIBLE      = 480,
    parameter int ROW_FRONT_PORCH  = 10,
    parameter int ROW_SYNC_PULSE   = 2,
    parameter int ROW_BACK_PORCH   = 33,
    parameter int SYNC_POLARITY    = 0,
    parameter int PIXEL_BITS       = 4,
    parameter int H_REPEAT         = 2,
    parameter int V_REPEAT         = 2,
    parameter int READ_LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  v_sync_out,
    output logic                  h_sync_out,
    output logic [PIXEL_BITS-1:0] gray_out,
    output logic                  frame_start,
    input  logic [PIXEL_BITS-1:0] data_in,
    output logic [PIXEL_BITS+3:0] ctrl_data_out,
    input  logic [PIXEL_BITS-1:0] write_data_in,
    input  logic                  reset_write_ptr,
    input  logic                  write_data,
    output logic                  wrote_data
);

    localparam int H_TOTAL = LINE_VISIBLE + LINE_FRONT_PORCH + LINE_SYNC_PULSE + LINE_BACK_PORCH;
    localparam int V_TOTAL = ROW_VISIBLE + ROW_FRONT_PORCH + ROW_SYNC_PULSE + ROW_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int COLS    = LINE_VISIBLE / H_REPEAT;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HPW     = (H_REPEAT > 1) ? $clog2(H_REPEAT) : 1;
    localparam int VPW     = (V_REPEAT > 1) ? $clog2(V_REPEAT) : 1;
    localparam int LEAD    = READ_LATENCY + 1;

    localparam logic [HW-1:0]  c_h_last     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  c_h_vis      = HW'(LINE_VISIBLE);
    localparam logic [HW-1:0]  c_hs_start   = HW'(LINE_VISIBLE + LINE_FRONT_PORCH);
    localparam logic [HW-1:0]  c_hs_end     = HW'(LINE_VISIBLE + LINE_FRONT_PORCH + LINE_SYNC_PULSE);
    localparam logic [VW-1:0]  c_v_last     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  c_v_vis      = VW'(ROW_VISIBLE);
    localparam logic [VW-1:0]  c_vs_start   = VW'(ROW_VISIBLE + ROW_FRONT_PORCH);
    localparam logic [VW-1:0]  c_vs_end     = VW'(ROW_VISIBLE + ROW_FRONT_PORCH + ROW_SYNC_PULSE);
    localparam logic [HPW-1:0] c_hp_last    = HPW'(H_REPEAT - 1);
    localparam logic [VPW-1:0] c_vp_last    = VPW'(V_REPEAT - 1);
    localparam logic [HW-1:0]  c_lead_h     = HW'(LEAD);
    localparam logic [HPW-1:0] c_lead_phase = HPW'(LEAD % H_REPEAT);
    localparam logic [CW-1:0]  c_lead_col   = CW'(LEAD / H_REPEAT);

    logic [HW-1:0]  r_h;
    logic [VW-1:0]  r_v;
    logic [HW-1:0]  r_fh;
    logic [VW-1:0]  r_fv;
    logic [HPW-1:0] r_fph;
    logic [VPW-1:0] r_fvph;
    logic [CW-1:0]  r_fcol;
    logic [PIXEL_BITS-1:0] r_pix;
    logic [PIXEL_BITS-1:0] r_line_buf [COLS];
    logic           r_wrote;

    logic w_slot, w_fetch, w_read, w_hs, w_vs, w_vis;
    logic w_cap_slot, w_cap_fetch;
    logic [CW-1:0] w_cap_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Look-ahead position runs LEAD clocks ahead of the display counters so
    // the read strobe for a column leaves room for the bus latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fh   <= c_lead_h;
            r_fv   <= '0;
            r_fph  <= c_lead_phase;
            r_fcol <= c_lead_col;
            r_fvph <= '0;
        end else if (r_fh == c_h_last) begin
            r_fh   <= '0;
            r_fph  <= '0;
            r_fcol <= '0;
            if (r_fv == c_v_last) begin
                r_fv   <= '0;
                r_fvph <= '0;
            end else begin
                r_fv   <= r_fv + 1'b1;
                r_fvph <= (r_fvph == c_vp_last) ? '0 : r_fvph + 1'b1;
            end
        end else begin
            r_fh <= r_fh + 1'b1;
            if (r_fph == c_hp_last) begin
                r_fph  <= '0;
                r_fcol <= r_fcol + 1'b1;
            end else begin
                r_fph <= r_fph + 1'b1;
            end
        end
    end

    assign w_slot  = (r_fh < c_h_vis) && (r_fph == '0) && (r_fv < c_v_vis);
    assign w_fetch = w_slot && (r_fvph == '0);
    assign w_read  = w_fetch & rst_n;

    // Slot/column markers delayed to the clock where the bus data is valid;
    // replay slots ride the same pipe so both line kinds share one timing.
    generate
        if (READ_LATENCY == 0) begin : g_lat_zero
            assign w_cap_slot  = w_slot;
            assign w_cap_fetch = w_fetch;
            assign w_cap_col   = r_fcol;
        end else begin : g_lat_pipe
            logic [READ_LATENCY-1:0] r_slot_pipe;
            logic [READ_LATENCY-1:0] r_fetch_pipe;
            logic [CW-1:0]           r_col_pipe [READ_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot_pipe  <= '0;
                    r_fetch_pipe <= '0;
                    for (int i = 0; i < READ_LATENCY; i++) begin
                        r_col_pipe[i] <= '0;
                    end
                end else begin
                    r_slot_pipe[0]  <= w_slot;
                    r_fetch_pipe[0] <= w_fetch;
                    r_col_pipe[0]   <= r_fcol;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        r_slot_pipe[i]  <= r_slot_pipe[i-1];
                        r_fetch_pipe[i] <= r_fetch_pipe[i-1];
                        r_col_pipe[i]   <= r_col_pipe[i-1];
                    end
                end
            end

            assign w_cap_slot  = r_slot_pipe[READ_LATENCY-1];
            assign w_cap_fetch = r_fetch_pipe[READ_LATENCY-1];
            assign w_cap_col   = r_col_pipe[READ_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= '0;
        end else if (w_cap_slot) begin
            r_pix <= w_cap_fetch ? data_in : r_line_buf[w_cap_col];
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap_slot && w_cap_fetch) begin
            r_line_buf[w_cap_col] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrote <= 1'b0;
        end else begin
            r_wrote <= write_data;
        end
    end

    assign w_hs  = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs  = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_vis = (r_h < c_h_vis) && (r_v < c_v_vis);

    assign h_sync_out    = (SYNC_POLARITY != 0) ? w_hs : ~w_hs;
    assign v_sync_out    = (SYNC_POLARITY != 0) ? w_vs : ~w_vs;
    assign gray_out      = w_vis ? r_pix : '0;
    assign frame_start   = rst_n && (r_h == '0) && (r_v == '0);
    assign wrote_data    = r_wrote;
    assign ctrl_data_out = {w_read, w_vs, write_data, reset_write_ptr, write_data_in};

endmodule

`default_nettype wire

// File: tb/tb_vga_framebuffer_scaled.sv
// ============================================================================
//  Module  : tb_vga_framebuffer_scaled
//  Purpose : Self-checking bench for vga_framebuffer_scaled (two configurations)
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_framebuffer_scaled;

    localparam int LV = 40, LFP = 4, LSP = 6, LBP = 6;
    localparam int RV = 12, RFP = 2, RSP = 2, RBP = 4;
    localparam int HT = LV + LFP + LSP + LBP;
    localparam int VT = RV + RFP + RSP + RBP;
    localparam int FR = HT * VT;
    localparam int RST_AT = 3 * FR + 6 * HT + 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_a, data_b, wdi;
    logic       wd, rwp;
    logic       vs_a, hs_a, fs_a, wrote_a, vs_b, hs_b, fs_b, wrote_b;
    logic [3:0] gray_a, gray_b;
    logic [7:0] ctrl_a, ctrl_b;

    always #5 clk = ~clk;

    vga_framebuffer_scaled #(
        .LINE_VISIBLE(LV), .LINE_FRONT_PORCH(LFP), .LINE_SYNC_PULSE(LSP), .LINE_BACK_PORCH(LBP),
        .ROW_VISIBLE(RV), .ROW_FRONT_PORCH(RFP), .ROW_SYNC_PULSE(RSP), .ROW_BACK_PORCH(RBP),
        .SYNC_POLARITY(0), .PIXEL_BITS(4), .H_REPEAT(2), .V_REPEAT(2), .READ_LATENCY(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .v_sync_out(vs_a), .h_sync_out(hs_a), .gray_out(gray_a),
        .frame_start(fs_a), .data_in(data_a), .ctrl_data_out(ctrl_a), .write_data_in(wdi),
        .reset_write_ptr(rwp), .write_data(wd), .wrote_data(wrote_a)
    );

    vga_framebuffer_scaled #(
        .LINE_VISIBLE(LV), .LINE_FRONT_PORCH(LFP), .LINE_SYNC_PULSE(LSP), .LINE_BACK_PORCH(LBP),
        .ROW_VISIBLE(RV), .ROW_FRONT_PORCH(RFP), .ROW_SYNC_PULSE(RSP), .ROW_BACK_PORCH(RBP),
        .SYNC_POLARITY(1), .PIXEL_BITS(4), .H_REPEAT(1), .V_REPEAT(1), .READ_LATENCY(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .v_sync_out(vs_b), .h_sync_out(hs_b), .gray_out(gray_b),
        .frame_start(fs_b), .data_in(data_b), .ctrl_data_out(ctrl_b), .write_data_in(wdi),
        .reset_write_ptr(rwp), .write_data(wd), .wrote_data(wrote_b)
    );

    int   passed = 0, total = 0, n = 0, run_id = 0;
    bit   running = 0;
    logic wrote_model = 1'b0;
    logic hv [2][4];
    int   ha [2][4];
    int   ptr [2];
    int   reads_a, reads_b, fs_cnt, vs_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected behaviour at cycle n after reset release, from the timing rules.
    task automatic check_model(string nm, int rl, int hr, int vr, int pol,
                               logic hs, logic vs, logic [3:0] gray, logic fs,
                               logic rd, logic rrp);
        int h, v, frame, tgt, th, tv;
        logic hsi, vsi, erd;
        h     = n % HT;
        v     = (n / HT) % VT;
        frame = n / FR;
        hsi   = (h >= LV + LFP) && (h < LV + LFP + LSP);
        vsi   = (v >= RV + RFP) && (v < RV + RFP + RSP);
        chk({nm, ".h_sync"}, hs, (pol != 0) ? hsi : !hsi);
        chk({nm, ".v_sync"}, vs, (pol != 0) ? vsi : !vsi);
        chk({nm, ".reset_read_ptr"}, rrp, vsi);
        chk({nm, ".frame_start"}, fs, (h == 0) && (v == 0));
        tgt = n + rl + 1;
        th  = tgt % HT;
        tv  = (tgt / HT) % VT;
        erd = (th < LV) && (th % hr == 0) && (tv < RV) && (tv % vr == 0);
        chk({nm, ".read"}, rd, erd);
        if (!((h < LV) && (v < RV)))
            chk({nm, ".gray_blank"}, gray, 0);
        else if (frame >= 1)
            chk({nm, ".gray_pix"}, gray, ((v / vr) * (LV / hr) + h / hr) % 16);
    endtask

    task automatic check_reset(string nm, int pol, logic hs, logic vs, logic [3:0] gray,
                               logic rd, logic rrp, logic wr);
        chk({nm, ".rst_h_sync"}, hs, (pol != 0) ? 1'b0 : 1'b1);
        chk({nm, ".rst_v_sync"}, vs, (pol != 0) ? 1'b0 : 1'b1);
        chk({nm, ".rst_gray"}, gray, 0);
        chk({nm, ".rst_read"}, rd, 0);
        chk({nm, ".rst_rrp"}, rrp, 0);
        chk({nm, ".rst_wrote"}, wr, 0);
    endtask

    // Framebuffer bus: linear read pointer cleared by reset_read_ptr, returns
    // (address mod 16) rl clocks after each read, random junk otherwise.
    task automatic bus_step(int id, int rl, logic rd, logic rrp, output logic [3:0] d);
        if (!rst_n) begin
            ptr[id] = 0;
            for (int i = 0; i < 4; i++) hv[id][i] = 1'b0;
            d = 4'($urandom);
        end else begin
            for (int i = 3; i > 0; i--) begin
                hv[id][i] = hv[id][i-1];
                ha[id][i] = ha[id][i-1];
            end
            hv[id][0] = rd;
            ha[id][0] = ptr[id];
            if (rd) ptr[id]++;
            if (rrp) ptr[id] = 0;
            d = hv[id][rl] ? 4'(ha[id][rl] % 16) : 4'($urandom);
        end
    endtask

    task automatic body();
        logic [3:0] nd_a, nd_b;
        if (running) begin
            check_model("a", 1, 2, 2, 0, hs_a, vs_a, gray_a, fs_a, ctrl_a[7], ctrl_a[6]);
            check_model("b", 3, 1, 1, 1, hs_b, vs_b, gray_b, fs_b, ctrl_b[7], ctrl_b[6]);
            if (n == 0) begin
                reads_a = 0; reads_b = 0; fs_cnt = 0; vs_cnt = 0;
            end
            if (n < 2 * FR) fs_cnt += int'(fs_a);
            if (n >= FR && n < 2 * FR) begin
                reads_a += int'(ctrl_a[7]);
                reads_b += int'(ctrl_b[7]);
                vs_cnt  += int'(!vs_a);
            end
            if (n == 2 * FR - 1) begin
                chk("a.reads_per_frame", reads_a, (RV / 2) * (LV / 2));
                chk("b.reads_per_frame", reads_b, RV * LV);
                chk("a.frame_starts", fs_cnt, 2);
                chk("a.vsync_clocks", vs_cnt, RSP * HT);
            end
        end else begin
            check_reset("a", 0, hs_a, vs_a, gray_a, ctrl_a[7], ctrl_a[6], wrote_a);
            check_reset("b", 1, hs_b, vs_b, gray_b, ctrl_b[7], ctrl_b[6], wrote_b);
        end
        chk("a.wrote_hold", wrote_a, wrote_model);
        bus_step(0, 1, ctrl_a[7], ctrl_a[6], nd_a);
        bus_step(1, 3, ctrl_b[7], ctrl_b[6], nd_b);
        data_a = nd_a;
        data_b = nd_b;
        wd  = 1'($urandom_range(0, 1));
        rwp = 1'($urandom_range(0, 1));
        wdi = 4'($urandom);
        if (running && n == 10) begin
            wd = 1'b1; rwp = 1'b0; wdi = 4'hA;
        end
        if (running && run_id == 0 && n >= RST_AT - 1) wd = 1'b1;
        #1;
        chk("a.ctrl_write_side", ctrl_a[5:0], {wd, rwp, wdi});
        chk("b.ctrl_write_side", ctrl_b[5:0], {wd, rwp, wdi});
        chk("a.wrote_registered", wrote_a, wrote_model);
        chk("b.wrote_registered", wrote_b, wrote_model);
        if (running) n++;
    endtask

    task automatic tick();
        @(posedge clk);
        wrote_model = rst_n ? wd : 1'b0;
        @(negedge clk);
        #1;
        body();
    endtask

    initial begin
        rst_n = 1'b0; wd = 1'b0; rwp = 1'b0; wdi = '0; data_a = '0; data_b = '0;
        ptr[0] = 0; ptr[1] = 0;
        repeat (4) tick();

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        running = 1; n = 0;
        body();
        while (n <= RST_AT) tick();

        // Asynchronous reset mid-frame; outputs must drop before any clock edge.
        rst_n = 1'b0;
        #1;
        running = 0;
        wrote_model = 1'b0;
        check_reset("a", 0, hs_a, vs_a, gray_a, ctrl_a[7], ctrl_a[6], wrote_a);
        check_reset("b", 1, hs_b, vs_b, gray_b, ctrl_b[7], ctrl_b[6], wrote_b);
        repeat (5) tick();

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        running = 1; n = 0; run_id = 1;
        body();
        while (n < 3 * FR) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
